// File: rtl/alu_datapath_pipe_if.sv
// Instruction, result and debug bundle between the decoder/control FSM and
// the alu_datapath_pipe register file and ALU.
interface alu_datapath_pipe_if #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        op;
    logic [REG_AW-1:0] rs_a;
    logic [REG_AW-1:0] rs_b;
    logic [REG_AW-1:0] rd;
    logic              use_imm;
    logic [DATA_W-1:0] imm;
    logic              wb_en;
    logic              stall;
    logic              res_valid;
    logic [DATA_W-1:0] result;
    logic [REG_AW-1:0] res_rd;
    logic [3:0]        flags;
    logic              illegal;
    logic [REG_AW-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;

    modport master (
        output in_valid, op, rs_a, rs_b, rd, use_imm, imm, wb_en, stall, dbg_addr,
        input  in_ready, res_valid, result, res_rd, flags, illegal, dbg_data
    );

    modport slave (
        input  in_valid, op, rs_a, rs_b, rd, use_imm, imm, wb_en, stall, dbg_addr,
        output in_ready, res_valid, result, res_rd, flags, illegal, dbg_data
    );
endinterface

// File: rtl/alu_datapath_pipe.sv
// Two-stage register-file + ALU datapath: stage 1 captures operands, stage 2
// executes, writes back and updates {C,V,N,Z}. Optional macro: ALU_DP_FORWARD_EN.
module alu_datapath_pipe #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16,
    parameter int REG_AW   = 4,
    parameter int SH_W     = 4
) (
    input logic                 clk,
    input logic                 reset,
    alu_datapath_pipe_if.slave  dp
);
    localparam int MSB = DATA_W - 1;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_ADDC = 4'd1,
        OP_SUB  = 4'd2,
        OP_CMP  = 4'd3,
        OP_AND  = 4'd4,
        OP_OR   = 4'd5,
        OP_XOR  = 4'd6,
        OP_NOT  = 4'd7,
        OP_MOV  = 4'd8,
        OP_LSH  = 4'd9,
        OP_RSH  = 4'd10,
        OP_ASH  = 4'd11
    } alu_op_e;

    logic [DATA_W-1:0] regs_r [NUM_REGS];

    logic              s1_valid_r;
    logic [DATA_W-1:0] s1_a_r;
    logic [DATA_W-1:0] s1_b_r;
    logic [3:0]        s1_op_r;
    logic [REG_AW-1:0] s1_rd_r;
    logic              s1_wb_en_r;

    logic              res_valid_r;
    logic [DATA_W-1:0] result_r;
    logic [REG_AW-1:0] res_rd_r;
    logic [3:0]        flags_r;
    logic              illegal_r;

    logic [DATA_W:0]   add_s;
    logic [DATA_W:0]   sub_s;
    logic [SH_W-1:0]   shamt_s;
    logic              cin_s;
    logic [DATA_W-1:0] alu_res_s;
    logic              c_s;
    logic              v_s;
    logic              writes_s;
    logic              reserved_s;
    logic [DATA_W-1:0] opa_s;
    logic [DATA_W-1:0] opb_s;

    // Stage-2 ALU: result, carry/borrow, overflow and write-back qualification.
    always_comb begin
        cin_s      = (s1_op_r == OP_ADDC) ? flags_r[3] : 1'b0;
        add_s      = {1'b0, s1_a_r} + {1'b0, s1_b_r} + {{DATA_W{1'b0}}, cin_s};
        sub_s      = {1'b0, s1_a_r} - {1'b0, s1_b_r};
        shamt_s    = s1_b_r[SH_W-1:0];
        alu_res_s  = {DATA_W{1'b0}};
        c_s        = 1'b0;
        v_s        = 1'b0;
        writes_s   = 1'b1;
        reserved_s = 1'b0;
        case (s1_op_r)
            OP_ADD, OP_ADDC: begin
                alu_res_s = add_s[MSB:0];
                c_s       = add_s[DATA_W];
                v_s       = (s1_a_r[MSB] == s1_b_r[MSB]) && (add_s[MSB] != s1_a_r[MSB]);
            end
            OP_SUB, OP_CMP: begin
                // Bit DATA_W of the widened difference is the unsigned borrow.
                alu_res_s = sub_s[MSB:0];
                c_s       = sub_s[DATA_W];
                v_s       = (s1_a_r[MSB] != s1_b_r[MSB]) && (sub_s[MSB] != s1_a_r[MSB]);
                writes_s  = (s1_op_r == OP_SUB);
            end
            OP_AND: alu_res_s = s1_a_r & s1_b_r;
            OP_OR:  alu_res_s = s1_a_r | s1_b_r;
            OP_XOR: alu_res_s = s1_a_r ^ s1_b_r;
            OP_NOT: alu_res_s = ~s1_a_r;
            OP_MOV: alu_res_s = s1_b_r;
            OP_LSH: alu_res_s = s1_a_r << shamt_s;
            OP_RSH: alu_res_s = s1_a_r >> shamt_s;
            OP_ASH: alu_res_s = $unsigned($signed(s1_a_r) >>> shamt_s);
            default: begin
                writes_s   = 1'b0;
                reserved_s = 1'b1;
            end
        endcase
    end

    // Stage-1 operand select, with optional bypass of the stage-2 result.
    always_comb begin
        opa_s = regs_r[dp.rs_a];
        opb_s = dp.use_imm ? dp.imm : regs_r[dp.rs_b];
`ifdef ALU_DP_FORWARD_EN
        if (s1_valid_r && s1_wb_en_r && writes_s && !dp.stall) begin
            opa_s = (s1_rd_r == dp.rs_a) ? alu_res_s : opa_s;
            opb_s = (!dp.use_imm && (s1_rd_r == dp.rs_b)) ? alu_res_s : opb_s;
        end else begin
            opa_s = opa_s;
            opb_s = opb_s;
        end
`endif
    end

    // Pipeline, register file and flag state; everything freezes under stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
            s1_valid_r  <= 1'b0;
            s1_a_r      <= {DATA_W{1'b0}};
            s1_b_r      <= {DATA_W{1'b0}};
            s1_op_r     <= 4'd0;
            s1_rd_r     <= {REG_AW{1'b0}};
            s1_wb_en_r  <= 1'b0;
            res_valid_r <= 1'b0;
            result_r    <= {DATA_W{1'b0}};
            res_rd_r    <= {REG_AW{1'b0}};
            flags_r     <= 4'd0;
            illegal_r   <= 1'b0;
        end else if (!dp.stall) begin
            s1_valid_r <= dp.in_valid;
            if (dp.in_valid) begin
                s1_a_r     <= opa_s;
                s1_b_r     <= opb_s;
                s1_op_r    <= dp.op;
                s1_rd_r    <= dp.rd;
                s1_wb_en_r <= dp.wb_en;
            end
            res_valid_r <= s1_valid_r;
            illegal_r   <= s1_valid_r & reserved_s;
            if (s1_valid_r) begin
                result_r <= alu_res_s;
                res_rd_r <= s1_rd_r;
                if (!reserved_s) begin
                    flags_r <= {c_s, v_s, alu_res_s[MSB], (alu_res_s == {DATA_W{1'b0}})};
                end
                if (s1_wb_en_r && writes_s) begin
                    regs_r[s1_rd_r] <= alu_res_s;
                end
            end
        end else begin
            illegal_r <= 1'b0;
        end
    end

    assign dp.in_ready  = ~dp.stall;
    assign dp.res_valid = res_valid_r;
    assign dp.result    = result_r;
    assign dp.res_rd    = res_rd_r;
    assign dp.flags     = flags_r;
    assign dp.illegal   = illegal_r;
    assign dp.dbg_data  = regs_r[dp.dbg_addr];
endmodule

// File: tb/tb_alu_datapath_pipe.sv
// Directed bench for alu_datapath_pipe; expected values are hand-computed.
module tb_alu_datapath_pipe;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks_cnt = 0;
    int   errors_cnt = 0;
    logic [15:0] fwd_exp;

    alu_datapath_pipe_if #(.DATA_W(16), .REG_AW(4)) dp_if ();

    alu_datapath_pipe #(.DATA_W(16), .NUM_REGS(16), .REG_AW(4), .SH_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .dp    (dp_if.slave)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input logic [3:0] op_v, input logic [3:0] ra, input logic [3:0] rb,
                         input logic [3:0] rdv, input logic ui, input logic [15:0] im,
                         input logic wb);
        dp_if.in_valid = 1'b1;
        dp_if.op       = op_v;
        dp_if.rs_a     = ra;
        dp_if.rs_b     = rb;
        dp_if.rd       = rdv;
        dp_if.use_imm  = ui;
        dp_if.imm      = im;
        dp_if.wb_en    = wb;
    endtask

    task automatic idle();
        dp_if.in_valid = 1'b0;
    endtask

    // Issue one instruction and stop at the negedge after its execute edge.
    task automatic run_one(input logic [3:0] op_v, input logic [3:0] ra, input logic [3:0] rb,
                           input logic [3:0] rdv, input logic ui, input logic [15:0] im,
                           input logic wb);
        drive(op_v, ra, rb, rdv, ui, im, wb);
        step();
        idle();
        step();
    endtask

    task automatic peek(input string tag, input logic [3:0] addr, input logic [15:0] exp);
        dp_if.dbg_addr = addr;
        #1;
        check_value(tag, {16'd0, dp_if.dbg_data}, {16'd0, exp});
    endtask

    task automatic check_res(input string tag, input logic [15:0] res, input logic [3:0] flg);
        check_value({tag, "_valid"}, {31'd0, dp_if.res_valid}, 32'd1);
        check_value({tag, "_result"}, {16'd0, dp_if.result}, {16'd0, res});
        check_value({tag, "_flags"}, {28'd0, dp_if.flags}, {28'd0, flg});
    endtask

    initial begin
        dp_if.in_valid = 1'b0;
        dp_if.op       = 4'd0;
        dp_if.rs_a     = 4'd0;
        dp_if.rs_b     = 4'd0;
        dp_if.rd       = 4'd0;
        dp_if.use_imm  = 1'b0;
        dp_if.imm      = 16'd0;
        dp_if.wb_en    = 1'b0;
        dp_if.stall    = 1'b0;
        dp_if.dbg_addr = 4'd0;
        step();
        step();
        reset = 1'b0;
        step();

        check_value("rst_valid", {31'd0, dp_if.res_valid}, 32'd0);
        check_value("rst_result", {16'd0, dp_if.result}, 32'd0);
        check_value("rst_flags", {28'd0, dp_if.flags}, 32'd0);
        check_value("rst_illegal", {31'd0, dp_if.illegal}, 32'd0);
        check_value("rst_ready", {31'd0, dp_if.in_ready}, 32'd1);
        peek("rst_r3", 4'd3, 16'h0000);

        // MOV immediate
        run_one(4'd8, 4'd0, 4'd0, 4'd3, 1'b1, 16'h1234, 1'b1);
        check_res("mov", 16'h1234, 4'b0000);
        check_value("mov_rd", {28'd0, dp_if.res_rd}, 32'd3);
        peek("mov_r3", 4'd3, 16'h1234);

        // ADD overflow and carry
        run_one(4'd8, 4'd0, 4'd0, 4'd1, 1'b1, 16'h7FFF, 1'b1);
        run_one(4'd0, 4'd1, 4'd0, 4'd2, 1'b1, 16'h0001, 1'b1);
        check_res("add_ovf", 16'h8000, 4'b0110);
        peek("add_ovf_r2", 4'd2, 16'h8000);
        run_one(4'd8, 4'd0, 4'd0, 4'd1, 1'b1, 16'hFFFF, 1'b1);
        run_one(4'd0, 4'd1, 4'd0, 4'd2, 1'b1, 16'h0001, 1'b1);
        check_res("add_carry", 16'h0000, 4'b1001);
        peek("add_carry_r2", 4'd2, 16'h0000);

        // CMP: flags only, no write even with wb_en
        run_one(4'd8, 4'd0, 4'd0, 4'd1, 1'b1, 16'h0005, 1'b1);
        run_one(4'd3, 4'd1, 4'd0, 4'd1, 1'b1, 16'h0009, 1'b1);
        check_res("cmp", 16'hFFFC, 4'b1010);
        peek("cmp_r1", 4'd1, 16'h0005);
        peek("cmp_r2", 4'd2, 16'h0000);
        peek("cmp_r3", 4'd3, 16'h1234);

        // ADDC consumes C=1 from the CMP: 5 + 2 + 1
        run_one(4'd1, 4'd1, 4'd0, 4'd6, 1'b1, 16'h0002, 1'b1);
        check_res("addc", 16'h0008, 4'b0000);

        // Shifts use only B[3:0]; logic ops; SUB with register operand
        run_one(4'd8, 4'd0, 4'd0, 4'd7, 1'b1, 16'h8001, 1'b1);
        run_one(4'd11, 4'd7, 4'd0, 4'd8, 1'b1, 16'h0011, 1'b1);
        check_res("ash", 16'hC000, 4'b0010);
        run_one(4'd10, 4'd7, 4'd0, 4'd8, 1'b1, 16'h0001, 1'b1);
        check_res("rsh", 16'h4000, 4'b0000);
        run_one(4'd9, 4'd7, 4'd0, 4'd8, 1'b1, 16'h000F, 1'b1);
        check_res("lsh", 16'h8000, 4'b0010);
        run_one(4'd6, 4'd7, 4'd0, 4'd8, 1'b1, 16'h8001, 1'b1);
        check_res("xor", 16'h0000, 4'b0001);
        run_one(4'd7, 4'd7, 4'd0, 4'd8, 1'b1, 16'h0000, 1'b1);
        check_res("not", 16'h7FFE, 4'b0000);
        run_one(4'd4, 4'd7, 4'd0, 4'd8, 1'b1, 16'h00FF, 1'b1);
        check_res("and", 16'h0001, 4'b0000);
        run_one(4'd5, 4'd7, 4'd0, 4'd8, 1'b1, 16'h0F00, 1'b1);
        check_res("or", 16'h8F01, 4'b0010);
        run_one(4'd2, 4'd7, 4'd1, 4'd9, 1'b0, 16'h0000, 1'b1);
        check_res("sub", 16'h7FFC, 4'b0100);
        peek("sub_r9", 4'd9, 16'h7FFC);

        // Back-to-back dependency: r2 = r1 + r1, then r4 = r2 + 1
        run_one(4'd8, 4'd0, 4'd0, 4'd1, 1'b1, 16'h0003, 1'b1);
`ifdef ALU_DP_FORWARD_EN
        fwd_exp = 16'h0007;
`else
        fwd_exp = 16'h0001;
`endif
        drive(4'd0, 4'd1, 4'd1, 4'd2, 1'b0, 16'h0000, 1'b1);
        step();
        drive(4'd0, 4'd2, 4'd0, 4'd4, 1'b1, 16'h0001, 1'b1);
        step();
        check_value("dep_first", {16'd0, dp_if.result}, 32'h0006);
        idle();
        step();
        check_value("dep_second", {16'd0, dp_if.result}, {16'd0, fwd_exp});
        peek("dep_r4", 4'd4, fwd_exp);

        // Stall with one instruction in stage 1
        drive(4'd8, 4'd0, 4'd0, 4'd10, 1'b1, 16'h0ABC, 1'b1);
        step();
        idle();
        dp_if.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_value("stall_ready", {31'd0, dp_if.in_ready}, 32'd0);
            check_value("stall_valid", {31'd0, dp_if.res_valid}, 32'd0);
            check_value("stall_result", {16'd0, dp_if.result}, {16'd0, fwd_exp});
            peek("stall_r10", 4'd10, 16'h0000);
        end
        dp_if.stall = 1'b0;
        step();
        check_res("stall_release", 16'h0ABC, 4'b0000);
        peek("stall_r10_after", 4'd10, 16'h0ABC);
        step();
        check_value("stall_once", {31'd0, dp_if.res_valid}, 32'd0);

        // Reserved opcode: pulse illegal, no write, flags untouched
        run_one(4'd8, 4'd0, 4'd0, 4'd12, 1'b1, 16'h8000, 1'b1);
        check_res("pre_ill", 16'h8000, 4'b0010);
        run_one(4'd13, 4'd1, 4'd0, 4'd5, 1'b1, 16'h1111, 1'b1);
        check_res("ill", 16'h0000, 4'b0010);
        check_value("ill_pulse", {31'd0, dp_if.illegal}, 32'd1);
        peek("ill_r5", 4'd5, 16'h0000);
        step();
        check_value("ill_clear", {31'd0, dp_if.illegal}, 32'd0);

        // Reset while an ADD sits in stage 1
        drive(4'd0, 4'd1, 4'd0, 4'd11, 1'b1, 16'h0001, 1'b1);
        step();
        idle();
        reset = 1'b1;
        #1;
        check_value("mid_rst_valid", {31'd0, dp_if.res_valid}, 32'd0);
        check_value("mid_rst_flags", {28'd0, dp_if.flags}, 32'd0);
        peek("mid_rst_r1", 4'd1, 16'h0000);
        step();
        step();
        reset = 1'b0;
        step();
        check_value("post_rst_valid", {31'd0, dp_if.res_valid}, 32'd0);
        peek("post_rst_r11", 4'd11, 16'h0000);
        peek("post_rst_r3", 4'd3, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end
endmodule
